posit_decode_pipe: RTL and testbench

- Two-stage pipelined posit field extractor for the decoder path.
- Takes a raw N-bit posit and produces sign, regime value k, exponent and MSB-aligned fraction, plus zero/NaR flags.
- Regime run length comes from the leading-one detector in FPGA/dec, instantiated in stage 2.
- Valid/ready handshake on both sides; consumers are the downstream scale/mantissa datapath.

---
 rtl/posit_decode_pipe.sv | 194 +++++++++++++++++++
 tb/tb_posit_decode_pipe.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe -- two-stage pipelined posit field extractor.
//
// Stage 1 captures the sign, the absolute value body and the zero/NaR flags.
// Stage 2 finds the regime run length with a leading-one detector, then
// shifts the regime out to expose the exponent and the fraction.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input posit valid
//   in_ready   block accepts in_posit this cycle
//   in_posit   raw N-bit posit word
//   out_valid  decoded fields valid
//   out_ready  consumer accepts this cycle
//   out_sign   posit sign bit
//   out_k      signed regime value (KW bits)
//   out_exp    exponent field, zero-filled when truncated (ES bits)
//   out_frac   fraction after the exponent, MSB-aligned, no hidden bit (FW bits)
//   out_zero   input was all zeros
//   out_nar    input was NaR (1 followed by N-1 zeros)

// Leading-one detector: o_pos is the index of the highest set bit of i_vec,
// o_valid is low when i_vec is all zeros.
module posit_lod #(
  parameter int W  = 32,
  parameter int LW = $clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [LW-1:0] o_pos,
  output logic          o_valid
);

  // Scan upward so the highest set bit is the last one to write o_pos.
  always_comb begin
    o_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) begin
        o_pos = LW'(i);
      end
    end
  end

  assign o_valid = |i_vec;

endmodule

module posit_decode_pipe #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int KW = $clog2(N) + 1,
  parameter int FW = N - 3 - ES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_posit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [KW-1:0] out_k,
  output logic [ES-1:0] out_exp,
  output logic [FW-1:0] out_frac,
  output logic          out_zero,
  output logic          out_nar
);

  localparam int LW = $clog2(N);
  localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

  // Stage 1 registers
  logic          r_s1_valid;
  logic          r_s1_sign;
  logic          r_s1_zero;
  logic          r_s1_nar;
  logic [N-2:0]  r_s1_body;

  // Stage 2 (output) registers
  logic          r_s2_valid;
  logic          r_out_sign;
  logic [KW-1:0] r_out_k;
  logic [ES-1:0] r_out_exp;
  logic [FW-1:0] r_out_frac;
  logic          r_out_zero;
  logic          r_out_nar;

  // Handshake
  logic          w_s1_adv;
  logic          w_in_fire;
  logic          w_s2_load;

  // Stage 1 combinational
  logic [N-1:0]  w_abs;

  // Stage 2 combinational
  logic          w_r;
  logic [N-1:0]  w_vec;
  logic [LW-1:0] w_lod_pos;
  logic          w_lod_valid;
  logic [KW-1:0] w_m;
  logic [KW-1:0] w_k;
  logic [KW-1:0] w_shamt;
  logic [N-2:0]  w_rest;
  logic [ES-1:0] w_exp;
  logic [FW-1:0] w_frac;
  logic          w_special;

  // Stage 1 may advance when stage 2 is empty or is being drained.
  assign w_s1_adv  = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign w_in_fire = in_valid & in_ready;
  assign w_s2_load = w_s1_adv & r_s1_valid;

  assign w_abs = in_posit[N-1] ? (~in_posit + N'(1)) : in_posit;

  // Regime search: invert the body when the run is of ones so the detector
  // always looks for the first bit that differs from the leading regime bit.
  // The top bit of w_vec is the zero-extension; bit N-2 is always zero here.
  assign w_r   = r_s1_body[N-2];
  assign w_vec = {1'b0, (w_r ? ~r_s1_body : r_s1_body)};

  posit_lod #(
    .W  (N),
    .LW (LW)
  ) u_lod (
    .i_vec   (w_vec),
    .o_pos   (w_lod_pos),
    .o_valid (w_lod_valid)
  );

  // No terminator means the regime fills the whole body.
  assign w_m     = w_lod_valid ? (KW'(N - 2) - KW'(w_lod_pos)) : KW'(N - 1);
  assign w_k     = w_r ? (w_m - KW'(1)) : (KW'(0) - w_m);
  // Drop the regime run plus its terminator; a shift of N clears the body.
  assign w_shamt = w_m + KW'(1);
  assign w_rest  = r_s1_body << w_shamt;
  assign w_exp   = w_rest[N-2 -: ES];
  assign w_frac  = w_rest[N-2-ES -: FW];

  assign w_special = r_s1_zero | r_s1_nar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_nar   <= 1'b0;
      r_s1_body  <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_fire) begin
        r_s1_sign <= in_posit[N-1];
        r_s1_zero <= (in_posit == '0);
        r_s1_nar  <= (in_posit == NAR_WORD);
        r_s1_body <= w_abs[N-2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_sign <= 1'b0;
      r_out_k    <= '0;
      r_out_exp  <= '0;
      r_out_frac <= '0;
      r_out_zero <= 1'b0;
      r_out_nar  <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_load) begin
        r_out_sign <= r_s1_sign;
        r_out_zero <= r_s1_zero;
        r_out_nar  <= r_s1_nar;
        r_out_k    <= w_special ? '0 : w_k;
        r_out_exp  <= w_special ? '0 : w_exp;
        r_out_frac <= w_special ? '0 : w_frac;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_sign  = r_out_sign;
  assign out_k     = r_out_k;
  assign out_exp   = r_out_exp;
  assign out_frac  = r_out_frac;
  assign out_zero  = r_out_zero;
  assign out_nar   = r_out_nar;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Self-checking bench for posit_decode_pipe: an N=8/ES=1 instance carries the
// directed, backpressure, reset and random scenarios; an N=32/ES=2 instance
// checks the default configuration.
module tb_posit_decode_pipe;

  typedef struct packed {
    logic               s;
    logic signed [31:0] k;
    logic [31:0]        e;
    logic [63:0]        f;
    logic               z;
    logic               n;
  } dec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  // N=8, ES=1 instance
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_posit;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [3:0] out_k;
  logic [0:0] out_exp;
  logic [3:0] out_frac;
  logic       out_zero;
  logic       out_nar;

  // N=32, ES=2 instance
  logic        w32_in_valid;
  logic        w32_in_ready;
  logic [31:0] w32_in_posit;
  logic        w32_out_valid;
  logic        w32_out_ready;
  logic        w32_out_sign;
  logic [5:0]  w32_out_k;
  logic [1:0]  w32_out_exp;
  logic [26:0] w32_out_frac;
  logic        w32_out_zero;
  logic        w32_out_nar;

  posit_decode_pipe #(.N(8), .ES(1)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_k     (out_k),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_zero  (out_zero),
    .out_nar   (out_nar)
  );

  posit_decode_pipe dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w32_in_valid),
    .in_ready  (w32_in_ready),
    .in_posit  (w32_in_posit),
    .out_valid (w32_out_valid),
    .out_ready (w32_out_ready),
    .out_sign  (w32_out_sign),
    .out_k     (w32_out_k),
    .out_exp   (w32_out_exp),
    .out_frac  (w32_out_frac),
    .out_zero  (w32_out_zero),
    .out_nar   (w32_out_nar)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  dec_t exp_q[$];

  // Reference decode: walk the regime bit by bit, then read the bits after
  // the terminator as a left-justified (n-3)-bit field split into exp/frac.
  function automatic dec_t ref_dec(input int n, input int es, input longint unsigned p);
    dec_t d;
    longint unsigned mask;
    longint unsigned a;
    longint unsigned pad;
    int i, m, rem, fw;
    bit r;
    d    = '0;
    fw   = n - 3 - es;
    mask = (64'd1 << n) - 1;
    d.s  = p[n-1];
    d.z  = (p == 0);
    d.n  = (p == (64'd1 << (n - 1)));
    if (d.z || d.n) return d;
    a = d.s ? ((mask + 1 - p) & mask) : p;
    r = a[n-2];
    i = n - 2;
    m = 0;
    while (i >= 0 && a[i] == r) begin
      m++;
      i--;
    end
    d.k = r ? (m - 1) : -m;
    rem = (i >= 0) ? i : 0;
    pad = (a & ((64'd1 << rem) - 1)) << (n - 3 - rem);
    d.e = 32'(pad >> fw);
    d.f = pad & ((64'd1 << fw) - 1);
    return d;
  endfunction

  function automatic string fmt(input dec_t d);
    return $sformatf("s=%0b k=%0d e=%0d f=%0h z=%0b n=%0b", d.s, d.k, d.e, d.f, d.z, d.n);
  endfunction

  function automatic dec_t obs8();
    dec_t d;
    d   = '0;
    d.s = out_sign;
    d.k = {{28{out_k[3]}}, out_k};
    d.e = {31'b0, out_exp};
    d.f = {60'b0, out_frac};
    d.z = out_zero;
    d.n = out_nar;
    return d;
  endfunction

  function automatic dec_t obs32();
    dec_t d;
    d   = '0;
    d.s = w32_out_sign;
    d.k = {{26{w32_out_k[5]}}, w32_out_k};
    d.e = {30'b0, w32_out_exp};
    d.f = {37'b0, w32_out_frac};
    d.z = w32_out_zero;
    d.n = w32_out_nar;
    return d;
  endfunction

  // One cycle on the 8-bit instance: drive after the falling edge, sample
  // 1 ns later. Accepted words are queued with their reference decode; on
  // an output transfer the oldest expectation is handed back to the caller.
  task automatic step(input logic v, input logic [7:0] data, input logic rdy,
                      output bit in_fire, output bit out_fire, output dec_t obs,
                      output bit have_exp, output dec_t expd);
    @(negedge clk);
    in_valid  = v;
    in_posit  = data;
    out_ready = rdy;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    obs      = obs8();
    have_exp = 1'b0;
    expd     = '0;
    if (in_fire) exp_q.push_back(ref_dec(8, 1, 64'(data)));
    if (out_fire && exp_q.size() > 0) begin
      have_exp = 1'b1;
      expd     = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_posit = '0; out_ready = 1'b0;
    w32_in_valid = 1'b0; w32_in_posit = '0; w32_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if ({out_sign, out_k, out_exp, out_frac, out_zero, out_nar} !== 12'h000)
      $display("FAIL reset_fields: got %03h want 000",
               {out_sign, out_k, out_exp, out_frac, out_zero, out_nar});
    else n_pass++;
    n_checks++;
    if (w32_out_valid !== 1'b0) $display("FAIL reset_out_valid32: got %0b want 0", w32_out_valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit fi, fo, he;
    dec_t ob, ex;
    int lat;
    lat = -1;
    step(1'b1, 8'h40, 1'b1, fi, fo, ob, he, ex);
    for (int c = 1; c <= 6; c++) begin
      step(1'b0, 8'h00, 1'b1, fi, fo, ob, he, ex);
      if (fo) begin
        if (lat < 0) lat = c;
        n_checks++;
        if (!he || ob !== ex) $display("FAIL single_0x40: got %s want %s", fmt(ob), fmt(ex));
        else n_pass++;
        $display("single in=40 -> %s", fmt(ob));
      end
    end
    n_checks++;
    if (lat != 2) $display("FAIL single_latency: got %0d want 2", lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit fi, fo, he;
    dec_t ob, ex;
    logic [7:0] words[$];
    int stalls, outs, nwords;
    words = '{8'h58, 8'h20, 8'h7F, 8'h01};
    for (int i = 0; i < 40; i++) words.push_back(8'($urandom));
    nwords = words.size();
    stalls = 0;
    outs = 0;
    for (int i = 0; i < nwords + 4; i++) begin
      if (i < nwords) begin
        step(1'b1, words[i], 1'b1, fi, fo, ob, he, ex);
        if (!fi) stalls++;
      end else begin
        step(1'b0, 8'h00, 1'b1, fi, fo, ob, he, ex);
      end
      if (fo) begin
        outs++;
        n_checks++;
        if (!he || ob !== ex) $display("FAIL b2b_word%0d: got %s want %s", outs - 1, fmt(ob), fmt(ex));
        else n_pass++;
        if (outs <= 4) $display("b2b out%0d -> %s", outs - 1, fmt(ob));
      end
    end
    n_checks++;
    if (stalls != 0) $display("FAIL b2b_throughput: got %0d stalls want 0", stalls);
    else n_pass++;
    n_checks++;
    if (outs != nwords) $display("FAIL b2b_count: got %0d want %0d", outs, nwords);
    else n_pass++;
  endtask

  task automatic test_sign_special();
    bit fi, fo, he;
    dec_t ob, ex;
    logic [7:0] words[3];
    int outs;
    words = '{8'hC0, 8'h80, 8'h00};
    outs = 0;
    for (int i = 0; i < 8; i++) begin
      step((i < 3), (i < 3) ? words[i] : 8'h00, 1'b1, fi, fo, ob, he, ex);
      if (fo) begin
        n_checks++;
        if (!he || ob !== ex) $display("FAIL special_word%0d: got %s want %s", outs, fmt(ob), fmt(ex));
        else n_pass++;
        $display("special out%0d -> %s", outs, fmt(ob));
        outs++;
      end
    end
    n_checks++;
    if (outs != 3) $display("FAIL special_count: got %0d want 3", outs);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] words[4];
    dec_t q[$];
    dec_t held, ob, ex;
    bit seen, ready_dropped, fi;
    int hold, idx, outs, unstable;
    for (int i = 0; i < 4; i++) words[i] = 8'($urandom_range(1, 127));
    seen = 0; ready_dropped = 0; hold = 0; idx = 0; outs = 0; unstable = 0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1;
        hold = 5;
        held = obs8();
      end
      in_valid  = (idx < 4);
      in_posit  = (idx < 4) ? words[idx] : 8'h00;
      out_ready = (hold == 0);
      #1;
      if (hold > 0) begin
        if (!in_ready) ready_dropped = 1;
        if (!out_valid || obs8() !== held) unstable++;
        hold--;
      end
      fi = in_valid && in_ready;
      if (fi) begin
        q.push_back(ref_dec(8, 1, 64'(words[idx])));
        idx++;
      end
      if (out_valid && out_ready) begin
        ob = obs8();
        n_checks++;
        if (q.size() == 0) $display("FAIL bp_spurious: got %s want none", fmt(ob));
        else begin
          ex = q.pop_front();
          if (ob !== ex) $display("FAIL bp_word%0d: got %s want %s", outs, fmt(ob), fmt(ex));
          else n_pass++;
        end
        $display("bp out%0d -> %s", outs, fmt(ob));
        outs++;
      end
    end
    n_checks++;
    if (!ready_dropped) $display("FAIL bp_in_ready_drop: got in_ready stuck 1 want 0 while stalled");
    else n_pass++;
    n_checks++;
    if (unstable != 0) $display("FAIL bp_stable: got %0d changed cycles want 0", unstable);
    else n_pass++;
    n_checks++;
    if (outs != 4) $display("FAIL bp_count: got %0d want 4", outs);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    bit fi, fo, he;
    dec_t ob, ex;
    int stale;
    step(1'b1, 8'h58, 1'b0, fi, fo, ob, he, ex);
    step(1'b1, 8'h20, 1'b0, fi, fo, ob, he, ex);
    step(1'b0, 8'h00, 1'b0, fi, fo, ob, he, ex);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL midrst_full: got out_valid=%0b in_ready=%0b want 1/0", out_valid, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_async: got out_valid=%0b want 0", out_valid);
    else n_pass++;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %0b want 1", in_ready);
    else n_pass++;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 8'h00, 1'b1, fi, fo, ob, he, ex);
      if (fo) stale++;
    end
    n_checks++;
    if (stale != 0) $display("FAIL midrst_stale: got %0d outputs want 0", stale);
    else n_pass++;
  endtask

  task automatic test_random();
    bit fi, fo, he, prev_stall;
    dec_t ob, ex, prev_obs;
    logic [7:0] d;
    int sel, unstable, bad;
    prev_stall = 0; prev_obs = '0; unstable = 0; bad = 0;
    for (int c = 0; c < 700; c++) begin
      sel = $urandom_range(0, 19);
      d = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h80 : 8'($urandom);
      if (c < 680) step(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) < 6), fi, fo, ob, he, ex);
      else step(1'b0, 8'h00, 1'b1, fi, fo, ob, he, ex);
      if (prev_stall && (!out_valid || ob !== prev_obs)) unstable++;
      prev_stall = out_valid && !out_ready;
      prev_obs = ob;
      if (fo) begin
        n_checks++;
        if (!he || ob !== ex) begin
          if (bad < 10) $display("FAIL rand_word: got %s want %s", fmt(ob), fmt(ex));
          bad++;
        end else n_pass++;
      end
    end
    n_checks++;
    if (unstable != 0) $display("FAIL rand_stable: got %0d changed cycles want 0", unstable);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rand_drain: got %0d words left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_n32();
    logic [31:0] words[$];
    dec_t ex, ob;
    bit got;
    words.push_back(32'h4C000000);
    for (int i = 0; i < 15; i++) words.push_back($urandom);
    words.push_back(32'h80000000);
    words.push_back(32'hFFFFFFFF);
    foreach (words[i]) begin
      ex = ref_dec(32, 2, 64'(words[i]));
      @(negedge clk);
      w32_in_valid  = 1'b1;
      w32_in_posit  = words[i];
      w32_out_ready = 1'b1;
      @(negedge clk);
      w32_in_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 6 && !got; c++) begin
        #1;
        if (w32_out_valid) begin
          got = 1;
          ob = obs32();
          n_checks++;
          if (ob !== ex) $display("FAIL n32_word%0d: got %s want %s", i, fmt(ob), fmt(ex));
          else n_pass++;
          if (i == 0) begin
            $display("n32 in=4c000000 -> %s", fmt(ob));
            n_checks++;
            if (w32_out_k !== 6'd0 || w32_out_exp !== 2'b01 || w32_out_frac !== 27'h4000000)
              $display("FAIL n32_directed: got k=%0d e=%0b f=%h want k=0 e=01 f=4000000",
                       w32_out_k, w32_out_exp, w32_out_frac);
            else n_pass++;
          end
        end else begin
          @(negedge clk);
        end
      end
      if (!got) begin
        n_checks++;
        $display("FAIL n32_timeout%0d: got no out_valid want one within 6 cycles", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sign_special();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_n32();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
